// File: rtl/hazard_pkg.sv
// Shared constants and types for the ID-stage hazard scoreboard.
// The decoder drives ID_Latency from the LAT_* constants below.
package hazard_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int REG_AW_DEF   = 5;
    localparam int MAX_LAT_DEF  = 7;
    localparam int CNT_W_DEF    = $clog2(MAX_LAT_DEF + 1);

    // Result latencies per instruction class, counted from issue until the
    // value can be read from the register file in ID.
    localparam int LAT_ALU  = 3;
    localparam int LAT_LOAD = 4;
    localparam int LAT_MUL  = 5;

    typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage bundle between the decoder (master) and the hazard scoreboard (slave).
// Optional macro FORWARD_EN adds the bypass latency input and forward-select outputs.
interface hazard_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 3
);
    logic              ID_valid;
    logic              ID_kill;
    logic [REG_AW-1:0] ID_rs;
    logic [REG_AW-1:0] ID_rt;
    logic              ID_use_rs;
    logic              ID_use_rt;
    logic              ID_RegWrite;
    logic [REG_AW-1:0] ID_WriteRegister;
    logic [CNT_W-1:0]  ID_Latency;
    logic              ID_stall;
    logic              ID_issue;
    logic [NUM_REGS-1:0] busy_vec;
`ifdef FORWARD_EN
    logic [CNT_W-1:0]  ID_FwdLatency;
    logic              rs_fwd;
    logic              rt_fwd;
    logic [CNT_W-1:0]  rs_fwd_age;
    logic [CNT_W-1:0]  rt_fwd_age;

    modport master (
        output ID_valid, ID_kill, ID_rs, ID_rt, ID_use_rs, ID_use_rt,
               ID_RegWrite, ID_WriteRegister, ID_Latency, ID_FwdLatency,
        input  ID_stall, ID_issue, busy_vec, rs_fwd, rt_fwd, rs_fwd_age, rt_fwd_age
    );

    modport slave (
        input  ID_valid, ID_kill, ID_rs, ID_rt, ID_use_rs, ID_use_rt,
               ID_RegWrite, ID_WriteRegister, ID_Latency, ID_FwdLatency,
        output ID_stall, ID_issue, busy_vec, rs_fwd, rt_fwd, rs_fwd_age, rt_fwd_age
    );
`else
    modport master (
        output ID_valid, ID_kill, ID_rs, ID_rt, ID_use_rs, ID_use_rt,
               ID_RegWrite, ID_WriteRegister, ID_Latency,
        input  ID_stall, ID_issue, busy_vec
    );

    modport slave (
        input  ID_valid, ID_kill, ID_rs, ID_rt, ID_use_rs, ID_use_rt,
               ID_RegWrite, ID_WriteRegister, ID_Latency,
        output ID_stall, ID_issue, busy_vec
    );
`endif
endinterface

// File: rtl/hazard_scoreboard_entry.sv
// One per-register countdown: loads the result latency on issue, then counts
// down to zero. A load wins over the decrement in the same cycle.
module scoreboard_entry #(
    parameter int CNT_W = 3
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt
);

    // Counter register: load, else decrement while nonzero, else hold at zero.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: one countdown per architectural register,
// stalling RAW reads of pending registers and younger writes that would land
// before an older, longer-latency write. Register 0 has no counter.
// Optional macro FORWARD_EN: a second countdown per register tracks bypass
// availability; RAW stalls then wait only for the bypass, and the block
// reports which source can be forwarded and from which stage (its age).
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int MAX_LAT  = MAX_LAT_DEF,
    parameter int CNT_W    = $clog2(MAX_LAT + 1)
) (
    input logic Clk,
    input logic Rst_n,
    hazard_scoreboard_if.slave id
);

    // Index space is padded to 2**REG_AW so any encoded index reads a defined
    // zero when NUM_REGS is not a power of two.
    localparam int IDX_N = 1 << REG_AW;

    logic [CNT_W-1:0] cnt [IDX_N];
    logic [CNT_W-1:0] rs_cnt;
    logic [CNT_W-1:0] rt_cnt;
    logic [CNT_W-1:0] wr_cnt;
    logic             raw_rs;
    logic             raw_rt;
    logic             waw;
    logic             stall;
    logic             issue;
`ifdef FORWARD_EN
    logic [CNT_W-1:0] fcnt [IDX_N];
    logic [CNT_W-1:0] rs_fcnt;
    logic [CNT_W-1:0] rt_fcnt;
`endif

    for (genvar i = 0; i < IDX_N; i++) begin : g_reg
        if (i == 0 || i >= NUM_REGS) begin : g_zero
            assign cnt[i] = '0;
`ifdef FORWARD_EN
            assign fcnt[i] = '0;
`endif
        end else begin : g_entry
            logic ld;
            assign ld = issue && id.ID_RegWrite &&
                        (id.ID_WriteRegister == REG_AW'(i));

            scoreboard_entry #(.CNT_W(CNT_W)) u_cnt (
                .Clk      (Clk),
                .Rst_n    (Rst_n),
                .load     (ld),
                .load_val (id.ID_Latency),
                .cnt      (cnt[i])
            );
`ifdef FORWARD_EN
            scoreboard_entry #(.CNT_W(CNT_W)) u_fcnt (
                .Clk      (Clk),
                .Rst_n    (Rst_n),
                .load     (ld),
                .load_val (id.ID_FwdLatency),
                .cnt      (fcnt[i])
            );
`endif
        end
    end

    // Hazard detection and issue decision, purely from ID inputs and the counters.
    always_comb begin
        rs_cnt = cnt[id.ID_rs];
        rt_cnt = cnt[id.ID_rt];
        wr_cnt = cnt[id.ID_WriteRegister];
`ifdef FORWARD_EN
        rs_fcnt = fcnt[id.ID_rs];
        rt_fcnt = fcnt[id.ID_rt];
        raw_rs  = id.ID_valid && id.ID_use_rs && (id.ID_rs != '0) && (rs_fcnt != '0);
        raw_rt  = id.ID_valid && id.ID_use_rt && (id.ID_rt != '0) && (rt_fcnt != '0);
`else
        raw_rs  = id.ID_valid && id.ID_use_rs && (id.ID_rs != '0) && (rs_cnt != '0);
        raw_rt  = id.ID_valid && id.ID_use_rt && (id.ID_rt != '0) && (rt_cnt != '0);
`endif
        // An equal-or-longer new latency cannot overtake the pending write.
        waw     = id.ID_valid && id.ID_RegWrite && (id.ID_WriteRegister != '0) &&
                  (wr_cnt > id.ID_Latency);
        // Kill does not mask the stall; it only prevents issue.
        stall   = Rst_n && (raw_rs || raw_rt || waw);
        issue   = Rst_n && id.ID_valid && !id.ID_kill && !stall;
    end

    assign id.ID_stall = stall;
    assign id.ID_issue = issue;

    // Debug view of pending registers; bit 0 is always clear.
    always_comb begin
        id.busy_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            id.busy_vec[i] = (cnt[i] != '0);
        end
    end

`ifdef FORWARD_EN
    // Forward select: result still pending in the register file but already on a bypass.
    always_comb begin
        id.rs_fwd     = id.ID_use_rs && (id.ID_rs != '0) && (rs_cnt != '0) && (rs_fcnt == '0);
        id.rt_fwd     = id.ID_use_rt && (id.ID_rt != '0) && (rt_cnt != '0) && (rt_fcnt == '0);
        id.rs_fwd_age = rs_cnt;
        id.rt_fwd_age = rt_cnt;
    end
`endif

    // Writes must carry a latency of 1..MAX_LAT; anything else leaves the
    // scoreboard meaningless.
    property p_lat_legal;
        @(posedge Clk) disable iff (!Rst_n)
            (id.ID_valid && id.ID_RegWrite) |->
                ((id.ID_Latency != '0) && (int'(id.ID_Latency) <= MAX_LAT));
    endproperty
    a_lat_legal: assert property (p_lat_legal);

`ifdef FORWARD_EN
    property p_fwd_lat_legal;
        @(posedge Clk) disable iff (!Rst_n)
            (id.ID_valid && id.ID_RegWrite) |-> (id.ID_FwdLatency <= id.ID_Latency);
    endproperty
    a_fwd_lat_legal: assert property (p_fwd_lat_legal);
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard. The reference model tracks, per
// register, the absolute cycle at which its result becomes readable (and, with
// FORWARD_EN, bypassable); expectations are pushed on stimulus and popped by
// an independent monitor on the falling edge.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NR = NUM_REGS_DEF;
    localparam int AW = REG_AW_DEF;
    localparam int CW = $clog2(MAX_LAT_DEF + 1);

    typedef struct {
        logic          valid, kill, use_rs, use_rt, rw;
        logic [AW-1:0] rs, rt, wr;
        int            lat, fwd;
    } op_t;

    typedef struct {
        string         tag;
        logic          stall, issue;
        logic [NR-1:0] busy;
        logic          rs_fwd, rt_fwd;
        int            rs_age, rt_age;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    hazard_scoreboard_if #(.NUM_REGS(NR), .REG_AW(AW), .CNT_W(CW)) id_bus ();

    hazard_scoreboard #(
        .NUM_REGS (NR),
        .REG_AW   (AW),
        .MAX_LAT  (MAX_LAT_DEF),
        .CNT_W    (CW)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .id    (id_bus)
    );

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_at[NR];
    int   fready_at[NR];
    logic pend_ld = 1'b0;
    int   pend_wr, pend_lat, pend_fwd;
    logic last_issue = 1'b0;
    op_t  prev_op;

    function automatic int rem(input int r);
        if (r == 0 || ready_at[r] <= cyc) return 0;
        return ready_at[r] - cyc;
    endfunction

    function automatic int frem(input int r);
        if (r == 0 || fready_at[r] <= cyc) return 0;
        return fready_at[r] - cyc;
    endfunction

    function automatic op_t mk(input logic valid, input logic kill,
                               input int rs, input logic use_rs,
                               input int rt, input logic use_rt,
                               input logic rw, input int wr, input int lat, input int fwd);
        op_t o;
        o.valid = valid; o.kill = kill;
        o.rs = AW'(rs); o.use_rs = use_rs;
        o.rt = AW'(rt); o.use_rt = use_rt;
        o.rw = rw; o.wr = AW'(wr); o.lat = lat; o.fwd = fwd;
        return o;
    endfunction

    task automatic drive(input op_t o);
        id_bus.ID_valid         = o.valid;
        id_bus.ID_kill          = o.kill;
        id_bus.ID_rs            = o.rs;
        id_bus.ID_rt            = o.rt;
        id_bus.ID_use_rs        = o.use_rs;
        id_bus.ID_use_rt        = o.use_rt;
        id_bus.ID_RegWrite      = o.rw;
        id_bus.ID_WriteRegister = o.wr;
        id_bus.ID_Latency       = CW'(o.lat);
`ifdef FORWARD_EN
        id_bus.ID_FwdLatency    = CW'(o.fwd);
`endif
    endtask

    function automatic exp_t model(input op_t o, input string tag);
        exp_t e;
        logic raw_rs, raw_rt, waw;
        e.tag = tag;
`ifdef FORWARD_EN
        raw_rs = o.valid && o.use_rs && o.rs != 0 && frem(int'(o.rs)) > 0;
        raw_rt = o.valid && o.use_rt && o.rt != 0 && frem(int'(o.rt)) > 0;
`else
        raw_rs = o.valid && o.use_rs && o.rs != 0 && rem(int'(o.rs)) > 0;
        raw_rt = o.valid && o.use_rt && o.rt != 0 && rem(int'(o.rt)) > 0;
`endif
        waw     = o.valid && o.rw && o.wr != 0 && rem(int'(o.wr)) > o.lat;
        e.stall = raw_rs || raw_rt || waw;
        e.issue = o.valid && !o.kill && !e.stall;
        for (int i = 0; i < NR; i++) e.busy[i] = (rem(i) > 0);
        e.rs_age = rem(int'(o.rs));
        e.rt_age = rem(int'(o.rt));
        e.rs_fwd = o.use_rs && o.rs != 0 && e.rs_age > 0 && frem(int'(o.rs)) == 0;
        e.rt_fwd = o.use_rt && o.rt != 0 && e.rt_age > 0 && frem(int'(o.rt)) == 0;
        return e;
    endfunction

    // One ID cycle: retire the previous issue into the model, present the op.
    task automatic step(input op_t o, input string tag);
        exp_t e;
        @(posedge Clk);
        cyc++;
        if (pend_ld) begin
            ready_at[pend_wr]  = cyc + pend_lat;
            fready_at[pend_wr] = cyc + pend_fwd;
        end
        pend_ld = 1'b0;
        #1;
        Rst_n = 1'b1;
        drive(o);
        e = model(o, tag);
        if (e.issue && o.rw && o.wr != 0) begin
            pend_ld  = 1'b1;
            pend_wr  = int'(o.wr);
            pend_lat = o.lat;
            pend_fwd = o.fwd;
        end
        q.push_back(e);
        last_issue = e.issue;
        prev_op = o;
    endtask

    // Assert reset mid-cycle; expectations are taken while still in reset.
    task automatic reset_cycle(input op_t o, input string tag);
        exp_t e;
        @(posedge Clk);
        cyc++;
        pend_ld = 1'b0;
        #1;
        Rst_n = 1'b0;
        drive(o);
        for (int i = 0; i < NR; i++) begin
            ready_at[i] = 0;
            fready_at[i] = 0;
        end
        e.tag = tag; e.stall = 1'b0; e.issue = 1'b0; e.busy = '0;
        e.rs_fwd = 1'b0; e.rt_fwd = 1'b0; e.rs_age = 0; e.rt_age = 0;
        q.push_back(e);
        last_issue = 1'b0;
        prev_op = o;
    endtask

    // Hold an instruction in ID until the model says it issues.
    task automatic issue_op(input op_t o, input string tag, input int budget);
        int n = 0;
        do begin
            step(o, tag);
            n++;
        end while (!last_issue && n < budget);
        if (!last_issue) begin
            checks++;
            errors++;
            $display("FAIL %s issue_timeout: not issued after %0d cycles, required issue", tag, n);
        end
    endtask

    task automatic chk(input string tag, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    // Monitor: compare the DUT against the oldest expectation on each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.tag, "ID_stall", 64'(id_bus.ID_stall), 64'(e.stall));
                chk(e.tag, "ID_issue", 64'(id_bus.ID_issue), 64'(e.issue));
                chk(e.tag, "busy_vec", 64'(id_bus.busy_vec), 64'(e.busy));
`ifdef FORWARD_EN
                chk(e.tag, "rs_fwd", 64'(id_bus.rs_fwd), 64'(e.rs_fwd));
                chk(e.tag, "rt_fwd", 64'(id_bus.rt_fwd), 64'(e.rt_fwd));
                chk(e.tag, "rs_fwd_age", 64'(id_bus.rs_fwd_age), 64'(e.rs_age));
                chk(e.tag, "rt_fwd_age", 64'(id_bus.rt_fwd_age), 64'(e.rt_age));
`endif
            end
        end
    end

    initial begin
        op_t idle, o;
        int  drain;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < NR; i++) begin
            ready_at[i] = 0;
            fready_at[i] = 0;
        end
        drive(idle);
        prev_op = idle;

        // Reset state, with a valid instruction present that must not issue.
        reset_cycle(mk(1, 0, 3, 1, 4, 1, 1, 5, LAT_LOAD, 1), "reset_state");
        step(idle, "reset_idle");

        // Reset in the middle of a pending load of r5.
        step(mk(1, 0, 1, 1, 2, 0, 1, 5, LAT_LOAD, 2), "r5_load");
        step(idle, "r5_busy");
        reset_cycle(mk(1, 0, 5, 1, 0, 0, 0, 0, 1, 0), "mid_reset");
        step(mk(1, 0, 5, 1, 0, 0, 0, 0, 1, 0), "after_reset_r5");

        // RAW on an ALU result.
        step(mk(1, 0, 1, 1, 2, 1, 1, 3, LAT_ALU, 1), "add_r3");
        issue_op(mk(1, 0, 3, 1, 2, 1, 1, 4, LAT_ALU, 1), "sub_r3", 10);
        repeat (4) step(idle, "drain_alu");

        // Register zero is never pending.
        step(mk(1, 0, 1, 1, 0, 0, 1, 0, LAT_LOAD, 2), "wr_r0");
        step(mk(1, 0, 0, 1, 0, 1, 1, 6, LAT_ALU, 1), "rd_r0");
        repeat (4) step(idle, "drain_r0");

        // WAW: same-or-longer latency passes, shorter latency waits.
        step(mk(1, 0, 1, 0, 0, 0, 1, 7, LAT_MUL, 3), "mul_r7");
        step(idle, "waw_gap");
        step(mk(1, 0, 1, 1, 0, 0, 1, 7, LAT_LOAD, 2), "lw_r7_lat4");
        repeat (6) step(idle, "drain_waw");
        step(mk(1, 0, 1, 0, 0, 0, 1, 7, LAT_MUL, 3), "mul_r7_b");
        issue_op(mk(1, 0, 1, 1, 0, 0, 1, 7, 2, 1), "lw_r7_lat2", 10);
        repeat (4) step(idle, "drain_waw2");

        // A killed, stalled instruction must not load its destination.
        step(mk(1, 0, 1, 0, 0, 0, 1, 9, LAT_MUL, 3), "mul_r9");
        step(mk(1, 1, 9, 1, 0, 0, 1, 10, LAT_ALU, 1), "kill_r10");
        step(idle, "kill_after");

        // Self-dependency on a free register issues and then marks it busy.
        repeat (6) step(idle, "drain_kill");
        step(mk(1, 0, 5, 1, 5, 1, 1, 5, 1, 0), "self_dep");
        step(mk(1, 0, 5, 1, 0, 0, 0, 0, 1, 0), "self_dep_rd");

        // Randomized traffic, mostly over a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_cycle(mk(1, 0, $urandom_range(0, 7), 1, $urandom_range(0, 7), 1,
                               1, $urandom_range(0, 7), 1, 0), "rand_reset");
            end else if (!last_issue && prev_op.valid && $urandom_range(0, 1) == 1) begin
                o = prev_op;
                o.kill = ($urandom_range(0, 9) == 0);
                step(o, "rand_hold");
            end else begin
                o.valid  = ($urandom_range(0, 99) < 85);
                o.kill   = ($urandom_range(0, 9) == 0);
                o.rs     = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NR - 1) : $urandom_range(0, 7));
                o.rt     = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NR - 1) : $urandom_range(0, 7));
                o.wr     = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NR - 1) : $urandom_range(0, 7));
                o.use_rs = $urandom_range(0, 1);
                o.use_rt = $urandom_range(0, 1);
                o.rw     = ($urandom_range(0, 99) < 70);
                o.lat    = $urandom_range(1, MAX_LAT_DEF);
                o.fwd    = $urandom_range(0, o.lat);
                step(o, "rand");
            end
        end

        step(idle, "final_idle");
        drain = 0;
        while (q.size() > 0 && drain < 10) begin
            @(posedge Clk);
            drain++;
        end
        @(posedge Clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
